// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Control bundles are ordered {pc_write, ifid_write, ifid_flush, idex_flush}.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN,
      LD_STALL,
      IMEM_WAIT
   } state_t;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] NOP      = 32'h0;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1};
   localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1};

   // A load in EX feeding a register read in ID; x0 is never a real dependency.
   function automatic logic load_use(input logic [4:0] id_rs1, input logic [4:0] id_rs2,
                                     input logic id_uses_rs1, input logic id_uses_rs2,
                                     input logic ex_mem_read, input logic [4:0] ex_rd);
      return ex_mem_read && (ex_rd != REG_ZERO) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic             branch_taken;
   logic             imem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             stall_active;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic             imem_timeout;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
             branch_taken, imem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
             stall_count, flush_count, imem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
             branch_taken, imem_ready,
      output pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
             stall_count, flush_count, imem_timeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^W.
module perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage front end: load-use stalls, taken-branch
// flushes, imem wait bubbles, plus stall/flush counters and a sticky imem timeout.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_LAT     = 1,
   parameter int IMEM_TIMEOUT = 16,
   parameter int CNT_W        = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  bus
);

   localparam int RW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int WW = $clog2(IMEM_TIMEOUT + 1);

   state_t         state, state_nxt;
   logic [RW-1:0]  remaining, remaining_nxt;
   logic [WW-1:0]  wait_cnt, wait_cnt_nxt, wait_inc;
   logic           timeout_q;
   logic           lu_haz;
   ctrl_t          ctl, ctl_out;

   assign lu_haz = load_use(bus.id_rs1, bus.id_rs2, bus.id_uses_rs1, bus.id_uses_rs2,
                            bus.ex_mem_read, bus.ex_rd);

   assign wait_inc = (wait_cnt == WW'(IMEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      wait_cnt_nxt  = wait_cnt;
      ctl           = CTRL_RUN;

      if (bus.branch_taken) begin
         ctl           = CTRL_FLUSH;
         state_nxt     = RUN;
         remaining_nxt = '0;
         wait_cnt_nxt  = '0;
      end else begin
         unique case (state)
            LD_STALL: begin
               ctl           = CTRL_LOAD_USE;
               remaining_nxt = remaining - 1'b1;
               if (remaining == RW'(1)) begin
                  state_nxt = RUN;
               end
            end
            IMEM_WAIT: begin
               if (lu_haz) begin
                  ctl = CTRL_LOAD_USE;
                  // Still waiting on imem: the load-use stall overlaps the wait.
                  if (!bus.imem_ready) begin
                     wait_cnt_nxt = wait_inc;
                  end else begin
                     wait_cnt_nxt = '0;
                     if (LOAD_LAT > 1) begin
                        state_nxt     = LD_STALL;
                        remaining_nxt = RW'(LOAD_LAT - 1);
                     end else begin
                        state_nxt = RUN;
                     end
                  end
               end else if (bus.imem_ready) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else begin
                  ctl          = CTRL_BUBBLE;
                  wait_cnt_nxt = wait_inc;
               end
            end
            default: begin
               if (lu_haz) begin
                  ctl          = CTRL_LOAD_USE;
                  wait_cnt_nxt = '0;
                  if (LOAD_LAT > 1) begin
                     state_nxt     = LD_STALL;
                     remaining_nxt = RW'(LOAD_LAT - 1);
                  end else begin
                     state_nxt = RUN;
                  end
               end else if (!bus.imem_ready) begin
                  ctl          = CTRL_BUBBLE;
                  state_nxt    = IMEM_WAIT;
                  wait_cnt_nxt = WW'(1);
               end
            end
         endcase
      end

      ctl_out = reset ? CTRL_RESET : ctl;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         remaining <= '0;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         wait_cnt  <= wait_cnt_nxt;
         timeout_q <= timeout_q | (wait_cnt_nxt == WW'(IMEM_TIMEOUT));
      end
   end

   assign bus.pc_write     = ctl_out.pc_write;
   assign bus.ifid_write   = ctl_out.ifid_write;
   assign bus.ifid_flush   = ctl_out.ifid_flush;
   assign bus.idex_flush   = ctl_out.idex_flush;
   assign bus.stall_active = !reset && !ctl.pc_write;
   assign bus.imem_timeout = timeout_q;

   perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (bus.stall_active),
      .count (bus.stall_count)
   );

   perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (bus.branch_taken),
      .count (bus.flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench: two controller instances (LOAD_LAT 1 and 3)
// share the same stimulus and are compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, imem_ready;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) bus_a ();
   pipeline_hazard_ctrl_if #(.CNT_W(8))  bus_b ();

   assign bus_a.id_rs1 = id_rs1;            assign bus_b.id_rs1 = id_rs1;
   assign bus_a.id_rs2 = id_rs2;            assign bus_b.id_rs2 = id_rs2;
   assign bus_a.id_uses_rs1 = id_uses_rs1;  assign bus_b.id_uses_rs1 = id_uses_rs1;
   assign bus_a.id_uses_rs2 = id_uses_rs2;  assign bus_b.id_uses_rs2 = id_uses_rs2;
   assign bus_a.ex_mem_read = ex_mem_read;  assign bus_b.ex_mem_read = ex_mem_read;
   assign bus_a.ex_rd = ex_rd;              assign bus_b.ex_rd = ex_rd;
   assign bus_a.branch_taken = branch_taken; assign bus_b.branch_taken = branch_taken;
   assign bus_a.imem_ready = imem_ready;    assign bus_b.imem_ready = imem_ready;

   pipeline_hazard_ctrl #(.LOAD_LAT(1), .IMEM_TIMEOUT(16), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   pipeline_hazard_ctrl #(.LOAD_LAT(3), .IMEM_TIMEOUT(4), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));

   // {pc_write, ifid_write, ifid_flush, idex_flush, stall_active}
   logic [4:0]  ctl_got   [2];
   logic [31:0] stall_got [2];
   logic [31:0] flush_got [2];
   logic        tmo_got   [2];

   assign ctl_got[0] = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_flush, bus_a.stall_active};
   assign ctl_got[1] = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_flush, bus_b.stall_active};
   assign stall_got[0] = bus_a.stall_count;
   assign stall_got[1] = {24'h0, bus_b.stall_count};
   assign flush_got[0] = bus_a.flush_count;
   assign flush_got[1] = {24'h0, bus_b.flush_count};
   assign tmo_got[0] = bus_a.imem_timeout;
   assign tmo_got[1] = bus_b.imem_timeout;

   localparam logic [4:0] E_RUN   = 5'b11000;
   localparam logic [4:0] E_LU    = 5'b00011;
   localparam logic [4:0] E_BUB   = 5'b01101;
   localparam logic [4:0] E_FLUSH = 5'b11110;
   localparam logic [4:0] E_RESET = 5'b00110;

   int          total = 0;
   int          bad   = 0;
   int          ll    [2] = '{1, 3};
   int          to    [2] = '{16, 4};
   logic [31:0] mask  [2] = '{32'hffff_ffff, 32'h0000_00ff};

   // Model: extra forced stall cycles left, whether a fetch is outstanding and for how long.
   int ld_left [2];
   int waited  [2];
   int stall_n [2];
   int flush_n [2];
   bit in_wait [2];
   bit tmo     [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         ld_left[d] = 0; waited[d] = 0; stall_n[d] = 0; flush_n[d] = 0;
         in_wait[d] = 1'b0; tmo[d] = 1'b0;
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s/dut%0d ctl", tag, d), 32'(ctl_got[d]), 32'(E_RESET));
         check($sformatf("%s/dut%0d stall_cnt", tag, d), stall_got[d], 32'h0);
         check($sformatf("%s/dut%0d flush_cnt", tag, d), flush_got[d], 32'h0);
         check($sformatf("%s/dut%0d tmo", tag, d), 32'(tmo_got[d]), 32'h0);
      end
   endtask

   // Called just after a rising edge with inputs already applied.
   task automatic step(input string tag);
      bit         haz;
      logic [4:0] e;
      #2;
      haz = ex_mem_read && (ex_rd != 5'd0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s/dut%0d stall_cnt", tag, d), stall_got[d], 32'(stall_n[d]) & mask[d]);
         check($sformatf("%s/dut%0d flush_cnt", tag, d), flush_got[d], 32'(flush_n[d]) & mask[d]);
         check($sformatf("%s/dut%0d tmo", tag, d), 32'(tmo_got[d]), 32'(tmo[d]));
         if (branch_taken) begin
            e = E_FLUSH; flush_n[d]++; ld_left[d] = 0; in_wait[d] = 1'b0; waited[d] = 0;
         end else if (ld_left[d] > 0) begin
            e = E_LU; ld_left[d]--;
         end else if (haz) begin
            e = E_LU;
            if (in_wait[d] && !imem_ready) begin
               waited[d] = (waited[d] + 1 > to[d]) ? to[d] : waited[d] + 1;
            end else begin
               in_wait[d] = 1'b0; waited[d] = 0; ld_left[d] = ll[d] - 1;
            end
         end else if (!imem_ready) begin
            e = E_BUB;
            waited[d]  = in_wait[d] ? ((waited[d] + 1 > to[d]) ? to[d] : waited[d] + 1) : 1;
            in_wait[d] = 1'b1;
         end else begin
            e = E_RUN; in_wait[d] = 1'b0; waited[d] = 0;
         end
         if (waited[d] >= to[d]) tmo[d] = 1'b1;
         if (!e[4]) stall_n[d]++;
         check($sformatf("%s/dut%0d ctl", tag, d), 32'(ctl_got[d]), 32'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_rd = 5'd0; branch_taken = 1'b0; imem_ready = 1'b1;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      idle_inputs();
      ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
   endtask

   // Async reset pulse placed mid-cycle, checked while asserted.
   task automatic mid_cycle_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_state(tag);
      #1;
      reset = 1'b0;
   endtask

   int burst;

   initial begin
      idle_inputs();
      model_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
      #11;
      check_reset_state("por");
      reset = 1'b0;
      @(posedge clk);
      #1;

      set_load_use(5'd5); step("lu_hit");
      idle_inputs();
      for (int i = 0; i < 4; i++) step("lu_drain");
      set_load_use(5'd0); step("lu_x0");
      idle_inputs(); step("lu_x0_after");

      set_load_use(5'd5); imem_ready = 1'b0; branch_taken = 1'b1; step("br_prio");
      idle_inputs(); step("br_prio_after");

      set_load_use(5'd5); step("br_abort_haz");
      idle_inputs(); branch_taken = 1'b1; step("br_abort_br");
      idle_inputs();
      for (int i = 0; i < 3; i++) step("br_abort_after");

      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) step("imem_wait");
      imem_ready = 1'b1;
      for (int i = 0; i < 2; i++) step("imem_resume");

      imem_ready = 1'b0;
      for (int i = 0; i < 18; i++) step("tmo_wait");
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) step("tmo_sticky");

      set_load_use(5'd5); step("rst_stall_haz");
      idle_inputs(); step("rst_stall_1");
      mid_cycle_reset("rst_mid_stall");
      step("rst_release");
      step("rst_release2");

      burst = 0;
      for (int n = 0; n < 3000; n++) begin
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         id_uses_rs1  = ($urandom_range(0, 9) < 7);
         id_uses_rs2  = ($urandom_range(0, 9) < 6);
         ex_mem_read  = ($urandom_range(0, 9) < 4);
         branch_taken = ($urandom_range(0, 11) == 0);
         if (burst > 0) begin
            imem_ready = 1'b0;
            burst--;
         end else begin
            if ($urandom_range(0, 39) == 0) burst = $urandom_range(2, 20);
            imem_ready = ($urandom_range(0, 4) != 0);
         end
         step("rand");
         if ($urandom_range(0, 599) == 0) mid_cycle_reset("rand_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
